// File: rtl/etapa_ex.sv
// MIPS execute stage: ALU, branch target and destination select, registered into EX/MEM.
// Define ETAPA_EX_MUL_EN to build the iterative shift-add multiplier and its stall FSM.
module etapa_ex (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        regwrite_in,
  input  logic        memtoreg_in,
  input  logic        memwrite_in,
  input  logic        memread_in,
  input  logic        branch_in,
  input  logic [2:0]  aluop_in,
  input  logic        alusrc_in,
  input  logic        regdst_in,
  input  logic [31:0] pcsumain_in,
  input  logic [31:0] data1_in,
  input  logic [31:0] data2_in,
  input  logic [31:0] signextender_in,
  input  logic [4:0]  instruccion_in,
  input  logic [4:0]  instruccion2_in,
  input  logic        flush_in,
  output logic        regwrite_out,
  output logic        memtoreg_out,
  output logic        memwrite_out,
  output logic        memread_out,
  output logic        branch_out,
  output logic [31:0] branchtarget_out,
  output logic        zero_out,
  output logic [31:0] aluresult_out,
  output logic [31:0] data2_out,
  output logic [4:0]  writereg_out,
  output logic        stall_out
);

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_ZERO,
    ALU_MUL
  } alu_op_e;

  typedef struct packed {
    logic        regwrite;
    logic        memtoreg;
    logic        memwrite;
    logic        memread;
    logic        branch;
    logic [31:0] branchtarget;
    logic        zero;
    logic [31:0] aluresult;
    logic [31:0] data2;
    logic [4:0]  writereg;
  } exmem_t;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  logic [31:0] w_opb;
  alu_op_e     w_op;
  logic [31:0] w_alu_res;
  logic [31:0] w_result;
  logic        w_stall;
  exmem_t      w_exmem;
  exmem_t      r_exmem;

  assign w_opb = alusrc_in ? signextender_in : data2_in;

  always_comb begin
    // NOTE: every combinational output gets a default before the case, so no path leaves it unassigned and no latch is inferred.
    w_op = ALU_ADD;
    case (aluop_in)
      3'b001: w_op = ALU_SUB;
      3'b010: begin
        case (signextender_in[5:0])
          FUNCT_ADD: w_op = ALU_ADD;
          FUNCT_SUB: w_op = ALU_SUB;
          FUNCT_AND: w_op = ALU_AND;
          FUNCT_OR:  w_op = ALU_OR;
          FUNCT_SLT: w_op = ALU_SLT;
`ifdef ETAPA_EX_MUL_EN
          6'b011000: w_op = ALU_MUL;
`endif
          default:   w_op = ALU_ZERO;
        endcase
      end
      3'b011:  w_op = ALU_AND;
      3'b100:  w_op = ALU_OR;
      3'b101:  w_op = ALU_SLT;
      default: w_op = ALU_ADD;
    endcase
  end

  always_comb begin
    w_alu_res = '0;
    case (w_op)
      ALU_ADD: w_alu_res = data1_in + w_opb;
      ALU_SUB: w_alu_res = data1_in - w_opb;
      ALU_AND: w_alu_res = data1_in & w_opb;
      ALU_OR:  w_alu_res = data1_in | w_opb;
      ALU_SLT: w_alu_res = {31'b0, $signed(data1_in) < $signed(w_opb)};
      default: w_alu_res = '0;
    endcase
  end

  always_comb begin
    w_exmem              = '0;
    w_exmem.regwrite     = regwrite_in;
    w_exmem.memtoreg     = memtoreg_in;
    w_exmem.memwrite     = memwrite_in;
    w_exmem.memread      = memread_in;
    w_exmem.branch       = branch_in;
    w_exmem.branchtarget = pcsumain_in + {signextender_in[29:0], 2'b00};
    w_exmem.zero         = (w_result == 32'd0);
    w_exmem.aluresult    = w_result;
    w_exmem.data2        = data2_in;
    w_exmem.writereg     = regdst_in ? instruccion2_in : instruccion_in;
  end

  // Flush outranks stall: both load a bubble, but only flush also resets the multiplier.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      r_exmem <= '0;
    end else if (flush_in || w_stall) begin
      r_exmem <= '0;
    end else begin
      r_exmem <= w_exmem;
    end
  end

`ifdef ETAPA_EX_MUL_EN
  localparam logic [5:0] MUL_LAST_STEP = 6'd31;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } mul_state_e;

  mul_state_e  r_state;
  mul_state_e  w_state_nxt;
  logic [31:0] r_mcand;
  logic [31:0] r_mplier;
  logic [31:0] r_acc;
  logic [5:0]  r_cnt;
  logic        w_is_mul;

  assign w_is_mul = (w_op == ALU_MUL);
  assign w_stall  = w_is_mul && (r_state != S_DONE);
  assign w_result = w_is_mul ? r_acc : w_alu_res;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_is_mul) w_state_nxt = S_BUSY;
      S_BUSY:  if (r_cnt == MUL_LAST_STEP) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else if (flush_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: the multiplier datapath has no reset; it is loaded in IDLE before BUSY or DONE ever read it.
  always_ff @(posedge clk) begin
    case (r_state)
      S_IDLE: begin
        if (w_is_mul) begin
          r_mcand  <= data1_in;
          r_mplier <= w_opb;
          r_acc    <= '0;
          r_cnt    <= '0;
        end
      end
      S_BUSY: begin
        if (r_mplier[0]) begin
          r_acc <= r_acc + r_mcand;
        end
        r_mcand  <= {r_mcand[30:0], 1'b0};
        r_mplier <= {1'b0, r_mplier[31:1]};
        r_cnt    <= r_cnt + 6'd1;
      end
      default: begin
      end
    endcase
  end
`else
  assign w_stall  = 1'b0;
  assign w_result = w_alu_res;
`endif

  assign stall_out        = w_stall;
  assign regwrite_out     = r_exmem.regwrite;
  assign memtoreg_out     = r_exmem.memtoreg;
  assign memwrite_out     = r_exmem.memwrite;
  assign memread_out      = r_exmem.memread;
  assign branch_out       = r_exmem.branch;
  assign branchtarget_out = r_exmem.branchtarget;
  assign zero_out         = r_exmem.zero;
  assign aluresult_out    = r_exmem.aluresult;
  assign data2_out        = r_exmem.data2;
  assign writereg_out     = r_exmem.writereg;

endmodule

// File: tb/tb_etapa_ex.sv
// Scoreboard bench for etapa_ex: expectations are queued at drive time and popped after the capturing edge.
module tb_etapa_ex;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        regwrite_in, memtoreg_in, memwrite_in, memread_in, branch_in;
  logic [2:0]  aluop_in;
  logic        alusrc_in, regdst_in;
  logic [31:0] pcsumain_in, data1_in, data2_in, signextender_in;
  logic [4:0]  instruccion_in, instruccion2_in;
  logic        flush_in;
  logic        regwrite_out, memtoreg_out, memwrite_out, memread_out, branch_out;
  logic [31:0] branchtarget_out;
  logic        zero_out;
  logic [31:0] aluresult_out, data2_out;
  logic [4:0]  writereg_out;
  logic        stall_out;

  always #5 clk = ~clk;

  etapa_ex u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .regwrite_in     (regwrite_in),
    .memtoreg_in     (memtoreg_in),
    .memwrite_in     (memwrite_in),
    .memread_in      (memread_in),
    .branch_in       (branch_in),
    .aluop_in        (aluop_in),
    .alusrc_in       (alusrc_in),
    .regdst_in       (regdst_in),
    .pcsumain_in     (pcsumain_in),
    .data1_in        (data1_in),
    .data2_in        (data2_in),
    .signextender_in (signextender_in),
    .instruccion_in  (instruccion_in),
    .instruccion2_in (instruccion2_in),
    .flush_in        (flush_in),
    .regwrite_out    (regwrite_out),
    .memtoreg_out    (memtoreg_out),
    .memwrite_out    (memwrite_out),
    .memread_out     (memread_out),
    .branch_out      (branch_out),
    .branchtarget_out(branchtarget_out),
    .zero_out        (zero_out),
    .aluresult_out   (aluresult_out),
    .data2_out       (data2_out),
    .writereg_out    (writereg_out),
    .stall_out       (stall_out)
  );

  typedef struct packed {
    logic        regwrite, memtoreg, memwrite, memread, branch;
    logic [2:0]  aluop;
    logic        alusrc, regdst;
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  rt, rd;
  } instr_t;

  typedef struct packed {
    logic        regwrite, memtoreg, memwrite, memread, branch;
    logic [31:0] bt;
    logic        zero;
    logic [31:0] res, d2;
    logic [4:0]  wr;
  } exmem_t;

  exmem_t sb_q[$];
  int     n_cmp = 0;
  int     n_bad = 0;

  function automatic instr_t mk(input logic [2:0] aluop, input logic alusrc, input logic regdst,
                                input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                                input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] pc,
                                input logic [4:0] ctrl);
    instr_t t;
    {t.regwrite, t.memtoreg, t.memwrite, t.memread, t.branch} = ctrl;
    t.aluop = aluop; t.alusrc = alusrc; t.regdst = regdst;
    t.d1 = d1; t.d2 = d2; t.imm = imm; t.rt = rt; t.rd = rd; t.pc = pc;
    return t;
  endfunction

  // Reference behaviour of one non-stalling instruction.
  function automatic exmem_t model(input instr_t t);
    exmem_t      e;
    logic [31:0] b, r;
    b = t.alusrc ? t.imm : t.d2;
    case (t.aluop)
      3'b001: r = t.d1 - b;
      3'b011: r = t.d1 & b;
      3'b100: r = t.d1 | b;
      3'b101: r = ($signed(t.d1) < $signed(b)) ? 32'd1 : 32'd0;
      3'b010: begin
        case (t.imm[5:0])
          6'h20:   r = t.d1 + b;
          6'h22:   r = t.d1 - b;
          6'h24:   r = t.d1 & b;
          6'h25:   r = t.d1 | b;
          6'h2a:   r = ($signed(t.d1) < $signed(b)) ? 32'd1 : 32'd0;
`ifdef ETAPA_EX_MUL_EN
          6'h18:   r = t.d1 * b;
`endif
          default: r = 32'd0;
        endcase
      end
      default: r = t.d1 + b;
    endcase
    e.regwrite = t.regwrite; e.memtoreg = t.memtoreg; e.memwrite = t.memwrite;
    e.memread = t.memread; e.branch = t.branch;
    e.bt   = t.pc + (t.imm << 2);
    e.zero = (r == 32'd0);
    e.res  = r;
    e.d2   = t.d2;
    e.wr   = t.regdst ? t.rd : t.rt;
    return e;
  endfunction

  function automatic exmem_t get_out();
    exmem_t o;
    o = {regwrite_out, memtoreg_out, memwrite_out, memread_out, branch_out,
         branchtarget_out, zero_out, aluresult_out, data2_out, writereg_out};
    return o;
  endfunction

  task automatic apply(input instr_t t, input logic fl);
    regwrite_in = t.regwrite; memtoreg_in = t.memtoreg; memwrite_in = t.memwrite;
    memread_in = t.memread; branch_in = t.branch;
    aluop_in = t.aluop; alusrc_in = t.alusrc; regdst_in = t.regdst;
    pcsumain_in = t.pc; data1_in = t.d1; data2_in = t.d2; signextender_in = t.imm;
    instruccion_in = t.rt; instruccion2_in = t.rd;
    flush_in = fl;
  endtask

  task automatic test_reset();
    instr_t t;
    exmem_t exp, got;
    t = mk(3'b000, 1'b0, 1'b1, 32'd1, 32'd2, 32'd4, 5'd1, 5'd2, 32'h10, 5'b11111);
    apply(t, 1'b0);
    @(posedge clk); #1;
    got = get_out();
    n_cmp++; if (got !== '0) begin n_bad++; $display("FAIL reset_outputs got %h want 0", got); end
    n_cmp++; if (stall_out !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %b want 0", stall_out); end
    @(negedge clk); rst_n = 1'b1;
    sb_q.push_back(model(t));
    @(posedge clk); #1;
    exp = sb_q.pop_front(); got = get_out();
    n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL reset_release_add got %h want %h", got, exp); end
    #2; rst_n = 1'b0; #1;
    got = get_out();
    n_cmp++; if (got !== '0) begin n_bad++; $display("FAIL reset_async got %h want 0", got); end
    n_cmp++; if (stall_out !== 1'b0) begin n_bad++; $display("FAIL reset_async_stall got %b want 0", stall_out); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_alu();
    instr_t v[12];
    exmem_t exp, got;
    v[0]  = mk(3'b010, 1'b0, 1'b1, 32'd5,        32'd5,        32'h0000_4822, 5'd4,  5'd9,  32'h200, 5'b10000);
    v[1]  = mk(3'b010, 1'b0, 1'b1, 32'h7FFF_FFFF, 32'd1,       32'h0000_2020, 5'd6,  5'd4,  32'h204, 5'b10000);
    v[2]  = mk(3'b010, 1'b0, 0,    32'h0000_F0F0, 32'h0000_FF00, 32'h0000_1824, 5'd3, 5'd11, 32'h208, 5'b10001);
    v[3]  = mk(3'b010, 1'b0, 1'b1, 32'h1200_0000, 32'h0000_0034, 32'h0000_6825, 5'd7, 5'd13, 32'h20C, 5'b11000);
    v[4]  = mk(3'b010, 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd2,       32'h0000_702A, 5'd8,  5'd14, 32'h210, 5'b10000);
    v[5]  = mk(3'b010, 1'b0, 1'b1, 32'd17,        32'd3,       32'h0000_783F, 5'd9,  5'd15, 32'h214, 5'b10000);
    v[6]  = mk(3'b000, 1'b1, 1'b0, 32'd10,        32'h55,      32'hFFFF_FFFC, 5'd10, 5'd1,  32'h218, 5'b01010);
    v[7]  = mk(3'b001, 1'b0, 1'b0, 32'd0,         32'd1,       32'h0000_0010, 5'd11, 5'd2,  32'h21C, 5'b00001);
    v[8]  = mk(3'b011, 1'b1, 1'b0, 32'hABCD_1234, 32'h0,       32'h0000_0FF0, 5'd12, 5'd3,  32'h220, 5'b10000);
    v[9]  = mk(3'b100, 1'b1, 1'b0, 32'h0000_0F00, 32'h1,       32'h0000_00F0, 5'd13, 5'd4,  32'h224, 5'b10000);
    v[10] = mk(3'b110, 1'b0, 1'b0, 32'd100,       32'd23,      32'h0000_0001, 5'd14, 5'd5,  32'h228, 5'b00100);
    v[11] = mk(3'b111, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1,       32'h0000_0002, 5'd15, 5'd6,  32'h22C, 5'b10000);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); apply(v[i], 1'b0);
      sb_q.push_back(model(v[i]));
      #1;
      n_cmp++; if (stall_out !== 1'b0) begin n_bad++; $display("FAIL alu_stall[%0d] got %b want 0", i, stall_out); end
      @(posedge clk); #1;
      exp = sb_q.pop_front(); got = get_out();
      n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL alu_vec[%0d] got %h want %h", i, got, exp); end
      if (i == 0) begin
        n_cmp++;
        if (aluresult_out !== 32'd0 || zero_out !== 1'b1 || writereg_out !== 5'd9) begin
          n_bad++;
          $display("FAIL rtype_sub got res=%h zero=%b wr=%0d want res=0 zero=1 wr=9", aluresult_out, zero_out, writereg_out);
        end
      end
    end
  endtask

  task automatic test_slt_branch();
    instr_t t;
    exmem_t exp, got;
    t = mk(3'b101, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd0, 32'd1, 5'd3, 5'd0, 32'h100, 5'b10000);
    @(negedge clk); apply(t, 1'b0); sb_q.push_back(model(t));
    @(posedge clk); #1;
    exp = sb_q.pop_front(); got = get_out();
    n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL slt_signed got %h want %h", got, exp); end
    n_cmp++; if (aluresult_out !== 32'd1) begin n_bad++; $display("FAIL slt_result got %h want 1", aluresult_out); end
    t = mk(3'b000, 1'b1, 1'b0, 32'd8, 32'd8, 32'hFFFF_FFFF, 5'd0, 5'd0, 32'h100, 5'b00001);
    @(negedge clk); apply(t, 1'b0); sb_q.push_back(model(t));
    @(posedge clk); #1;
    exp = sb_q.pop_front(); got = get_out();
    n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL branch_vec got %h want %h", got, exp); end
    n_cmp++; if (branchtarget_out !== 32'h0000_00FC) begin n_bad++; $display("FAIL branch_target got %h want 000000fc", branchtarget_out); end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  fn [7];
    instr_t      t;
    exmem_t      exp, got;
    logic [31:0] r;
    logic        fl;
    fn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h3f, 6'h00};
    for (int i = 0; i < 40; i++) begin
      r  = $urandom;
      fl = ($urandom_range(0, 7) == 0);
      t  = mk(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom, $urandom, {r[31:6], fn[$urandom_range(0, 6)]},
              5'($urandom), 5'($urandom), $urandom, 5'($urandom));
      @(negedge clk); apply(t, fl);
      sb_q.push_back(fl ? exmem_t'('0) : model(t));
      @(posedge clk); #1;
      exp = sb_q.pop_front(); got = get_out();
      n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL b2b[%0d] flush=%b got %h want %h", i, fl, got, exp); end
    end
  endtask

`ifdef ETAPA_EX_MUL_EN
  // One complete MUL: 33 stall cycles writing bubbles, then the product on the DONE edge.
  task automatic test_mul_run(input string name, input logic [31:0] a, input logic [31:0] b, input logic [31:0] prod);
    instr_t t;
    exmem_t exp, got;
    t = mk(3'b010, 1'b0, 1'b1, a, b, 32'h0000_1818, 5'd2, 5'd3, 32'h40, 5'b10000);
    @(negedge clk); apply(t, 1'b0);
    for (int c = 0; c < 33; c++) begin
      #1;
      n_cmp++; if (stall_out !== 1'b1) begin n_bad++; $display("FAIL %s_stall_c%0d got %b want 1", name, c, stall_out); end
      sb_q.push_back('0);
      @(posedge clk); #1;
      exp = sb_q.pop_front(); got = get_out();
      n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL %s_bubble_c%0d got %h want %h", name, c, got, exp); end
      @(negedge clk);
    end
    #1;
    n_cmp++; if (stall_out !== 1'b0) begin n_bad++; $display("FAIL %s_done_stall got %b want 0", name, stall_out); end
    exp = '0;
    exp.regwrite = 1'b1;
    exp.bt       = 32'h40 + (32'h0000_1818 << 2);
    exp.zero     = (prod == 32'd0);
    exp.res      = prod;
    exp.d2       = b;
    exp.wr       = 5'd3;
    sb_q.push_back(exp);
    @(posedge clk); #1;
    exp = sb_q.pop_front(); got = get_out();
    n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL %s_product got %h want %h", name, got, exp); end
  endtask

  task automatic test_mul();
    test_mul_run("mul_basic", 32'h0001_0003, 32'h0000_0007, 32'h0007_0015);
    test_mul_run("mul_b2b", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
  endtask

  task automatic test_flush();
    instr_t t, u;
    exmem_t exp, got;
    t = mk(3'b010, 1'b0, 1'b1, 32'h0000_1234, 32'h0000_5678, 32'h0000_1818, 5'd2, 5'd3, 32'h40, 5'b10000);
    @(negedge clk); apply(t, 1'b0);
    for (int c = 0; c < 10; c++) begin
      #1;
      n_cmp++; if (stall_out !== 1'b1) begin n_bad++; $display("FAIL flush_pre_stall_c%0d got %b want 1", c, stall_out); end
      sb_q.push_back('0);
      @(posedge clk); #1;
      exp = sb_q.pop_front(); got = get_out();
      n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL flush_pre_bubble_c%0d got %h want %h", c, got, exp); end
      @(negedge clk);
    end
    flush_in = 1'b1;
    sb_q.push_back('0);
    @(posedge clk); #1;
    exp = sb_q.pop_front(); got = get_out();
    n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL flush_bubble got %h want %h", got, exp); end
    for (int i = 0; i < 3; i++) begin
      u = mk(3'b000, 1'b0, 1'b0, 32'(i + 1), 32'd10, 32'd0, 5'(i + 20), 5'd0, 32'h80, 5'b10000);
      @(negedge clk); apply(u, 1'b0);
      #1;
      n_cmp++; if (stall_out !== 1'b0) begin n_bad++; $display("FAIL flush_after_stall[%0d] got %b want 0", i, stall_out); end
      sb_q.push_back(model(u));
      @(posedge clk); #1;
      exp = sb_q.pop_front(); got = get_out();
      n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL flush_after_add[%0d] got %h want %h", i, got, exp); end
    end
    test_mul_run("mul_after_flush", 32'h1234_5678, 32'h0000_0009, 32'hA3D7_0A38);
  endtask

  task automatic test_mul_reset();
    instr_t t;
    exmem_t got;
    t = mk(3'b010, 1'b0, 1'b1, 32'd6, 32'd7, 32'h0000_1818, 5'd2, 5'd3, 32'h40, 5'b10000);
    @(negedge clk); apply(t, 1'b0);
    repeat (6) @(posedge clk);
    #2; rst_n = 1'b0; #1;
    got = get_out();
    n_cmp++; if (got !== '0) begin n_bad++; $display("FAIL mul_reset_outputs got %h want 0", got); end
    n_cmp++; if (stall_out !== 1'b1) begin n_bad++; $display("FAIL mul_reset_stall got %b want 1", stall_out); end
    #1; rst_n = 1'b1;
    test_mul_run("mul_after_reset", 32'd6, 32'd7, 32'd42);
  endtask
`else
  task automatic test_nomul();
    instr_t t;
    exmem_t exp, got;
    t = mk(3'b010, 1'b0, 1'b1, 32'd3, 32'd4, 32'h0000_1818, 5'd2, 5'd3, 32'h40, 5'b10000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); apply(t, 1'b0);
      #1;
      n_cmp++; if (stall_out !== 1'b0) begin n_bad++; $display("FAIL nomul_stall[%0d] got %b want 0", i, stall_out); end
      sb_q.push_back(model(t));
      @(posedge clk); #1;
      exp = sb_q.pop_front(); got = get_out();
      n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL nomul_vec[%0d] got %h want %h", i, got, exp); end
      n_cmp++;
      if (aluresult_out !== 32'd0 || zero_out !== 1'b1) begin
        n_bad++;
        $display("FAIL nomul_result[%0d] got res=%h zero=%b want res=0 zero=1", i, aluresult_out, zero_out);
      end
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu();
    test_slt_branch();
    test_back_to_back();
`ifdef ETAPA_EX_MUL_EN
    test_mul();
    test_flush();
    test_mul_reset();
`else
    test_nomul();
`endif
    n_cmp++;
    if (sb_q.size() != 0) begin n_bad++; $display("FAIL scoreboard_drain got %0d left want 0", sb_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
